result_writeback: RTL and testbench
===================================

# result_writeback

Result write-back engine for the block matrix multiplier, sitting at the output end of the accumulator. It captures each 256-bit accumulated block on the rising edge of `done_accum` and stamps it with its row-major block address (row × 128 + col). It then buffers the result in a small FIFO and drains it into the output result RAM over a valid/ready write port. It is the writing counterpart of the operand-fetch path that reads `RAM_input`.

## Interface
- `DATA_W`, 256, result word width
- `ADDR_W`, 14, result RAM address width (16384 entries)
- `COLS`, 128, block columns per row
- `ROWS`, 128, block rows per frame
- `FIFO_DEPTH`, 4, buffered results (power of 2)

- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `out`  in  DATA_W  accumulator result; sampled on the `done_accum` rising edge
- `done_accum`  in  1  accumulator done; may stay high several cycles; only the 0→1 transition counts
- `wr_ready`  in  1  result RAM can accept a write this cycle
- `wr_en`  out  1  write request; reset 0
- `wr_addr`  out  ADDR_W  write address; reset 0
- `wr_data`  out  DATA_W  write data; reset 0
- `block_row`  out  ADDR_W/2  row of the next capture; reset 0
- `block_col`  out  ADDR_W/2  column of the next capture; reset 0
- `frame_done`  out  1  one-cycle pulse after the last block of a frame is written to the RAM; reset 0
- `overflow`  out  1  sticky flag, set when a capture is dropped; reset 0

## Operation
- Edge detect:
  - Register `done_prev`.
  - `capture = done_accum & ~done_prev`.
  - `done_prev` resets to 0, so `done_accum` high out of reset counts as an edge on the first active clock.
- Capture:
  - On `capture`, push {`block_row`*COLS + `block_col`, `out`} into the FIFO.
  - Address arithmetic is unsigned, truncated to ADDR_W.
- Counter advance:
  - `block_col` increments on every capture, including dropped ones, so addresses stay aligned.
  - At `block_col` == COLS-1, `block_col`→0 and `block_row` increments.
  - At row ROWS-1, col COLS-1, both wrap to 0.
- Drain:
  - `wr_en` = FIFO not empty.
  - `wr_addr`/`wr_data` = FIFO head.
  - A transfer occurs on an edge where `wr_en & wr_ready`; the head pops.
  - While `wr_en` is high and `wr_ready` is low, `wr_addr`/`wr_data` hold stable.
  - When the FIFO is empty, `wr_addr`/`wr_data` hold their last value (0 after reset).
- Full FIFO:
  - A capture with no pop on the same edge is dropped.
  - `overflow` is set and stays set until reset.
- Simultaneous push and pop: legal at any occupancy, including full; occupancy is unchanged.
- `frame_done` pulses on the cycle after the transfer whose address is ROWS*COLS-1, for every such transfer.
- Reset mid-operation clears the FIFO, counters, `overflow` and all outputs immediately (asynchronous); pending results are discarded.

## Timing
- Capture latency: `done_accum` 0→1 sampled at edge k → entry written at edge k → `wr_en` high in cycle k+1.
- Throughput: one transfer per cycle while `wr_ready` is held high; one capture per edge maximum.
- `wr_en` deasserts in the cycle after the last entry pops.
- The FIFO and counters change only on rising `clock`, apart from asynchronous reset.

## Structure
- Shared package holds `DATA_W`, `ADDR_W`, `COLS`, `ROWS`, and the block-address formula, reused by the operand-fetch sequencer.
- One sub-module, `wb_fifo`:
  - synchronous FIFO of width ADDR_W+DATA_W;
  - exposes `full`, `empty`, `push`, `pop` and a combinational head;
  - supports push and pop on the same edge when full.
- Top level contains the edge detector, row/col counters, overflow flag and frame_done logic.

## Test plan
- Reset release, `done_accum` pulsed 3 times 20 cycles apart, `wr_ready`=1 → three writes to addresses 0, 1, 2, each with its data; `wr_en` 1 cycle after each edge; `overflow`=0.
- `done_accum` held high for 10 cycles → exactly one capture; `block_col` ends at 1.
- 129 captures → 129th write at address 128; `block_row`=1 and `block_col`=1 afterwards.
- `wr_ready`=0 with 5 captures → 4 entries held; `overflow`=1; `wr_addr` stable at 0.
  - After release: writes to 0, 1, 2, 3.
  - Next capture is written to address 5.
- Full FIFO with `wr_ready`=1 and a capture on the same edge → no drop; `overflow` stays 0.
- 16384 captures → `frame_done` pulses once, one cycle after the write to 16383; next capture is written to address 0.
- Reset asserted while 2 entries are pending → `wr_en`, `wr_addr` and the counters are 0 immediately; after release, the next capture goes to address 0.

Source files
------------

// File: rtl/result_writeback_pkg.sv
// Shared block-matrix geometry and block-address formula, used by the write-back
// engine and the operand-fetch sequencer.
package result_writeback_pkg;

  localparam int DATA_W     = 256;
  localparam int ADDR_W     = 14;
  localparam int COLS       = 128;
  localparam int ROWS       = 128;
  localparam int FIFO_DEPTH = 4;
  localparam int RC_W       = ADDR_W / 2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } wb_entry_t;

  // Row-major block address, truncated to the RAM address width.
  function automatic logic [ADDR_W-1:0] block_addr(input logic [RC_W-1:0] row,
                                                   input logic [RC_W-1:0] col);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return r * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/result_writeback_fifo.sv
// Generic synchronous FIFO with combinational head.
// Latency: a push is visible at the head in the cycle after the push edge.
// Backpressure: a push while full is accepted only when a pop happens on the same edge.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage needs no reset: the head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_writeback.sv
// Captures accumulator results on done_accum rising edges, stamps the block address, drains to the result RAM.
// Latency: capture at edge k -> wr_en high in cycle k+1; one transfer per cycle while wr_ready is high.
// Backpressure: wr_ready low holds the FIFO head; a capture into a full FIFO without a same-edge pop is dropped and sets overflow.
module result_writeback
  import result_writeback_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] out,
  input  logic              done_accum,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [RC_W-1:0]   block_row,
  output logic [RC_W-1:0]   block_col,
  output logic              frame_done,
  output logic              overflow
);

  logic      done_prev;
  logic      capture;
  logic      transfer;
  logic      push;
  logic      fifo_full;
  logic      fifo_empty;
  wb_entry_t push_ent;
  wb_entry_t head_ent;
  wb_entry_t last_ent;
  wb_entry_t cur_ent;

  assign capture       = done_accum & ~done_prev;
  assign transfer      = wr_en & wr_ready;
  assign push          = capture & (~fifo_full | transfer);
  assign push_ent.addr = block_addr(block_row, block_col);
  assign push_ent.dat  = out;

  wb_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (push_ent),
    .pop      (transfer),
    .head     (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Once empty, the port keeps presenting the last written entry instead of stale storage.
  assign cur_ent = fifo_empty ? last_ent : head_ent;
  assign wr_en   = ~fifo_empty;
  assign wr_addr = cur_ent.addr;
  assign wr_data = cur_ent.dat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_prev  <= 1'b0;
      block_row  <= '0;
      block_col  <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
      last_ent   <= '0;
    end else begin
      done_prev  <= done_accum;
      frame_done <= transfer & (head_ent.addr == LAST_ADDR);
      if (capture & ~push) overflow <= 1'b1;
      if (transfer) last_ent <= head_ent;
      // Counters advance on dropped captures too, keeping later addresses aligned.
      if (capture) begin
        if (block_col == RC_W'(COLS - 1)) begin
          block_col <= '0;
          block_row <= (block_row == RC_W'(ROWS - 1)) ? '0 : block_row + 1'b1;
        end else begin
          block_col <= block_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: vector table for single-cycle behaviour,
// hand sequences for pulse spacing, row wrap, frame wrap and mid-run reset.
module tb_result_writeback;
  import result_writeback_pkg::*;

  logic              clock;
  logic              reset;
  logic [DATA_W-1:0] out;
  logic              done_accum;
  logic              wr_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [RC_W-1:0]   block_row;
  logic [RC_W-1:0]   block_col;
  logic              frame_done;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  result_writeback dut (
    .clock      (clock),
    .reset      (reset),
    .out        (out),
    .done_accum (done_accum),
    .wr_ready   (wr_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .block_row  (block_row),
    .block_col  (block_col),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit rst;
    bit done;
    bit rdy;
    int din;
    bit exp_en;
    int exp_addr;
    int exp_dseed;
    bit exp_ovf;
    int exp_col;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [DATA_W-1:0] dat(input int s);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(s);
    return {8{w}};
  endfunction

  function automatic vec_t mk(input bit rst, input bit done, input bit rdy, input int din,
                              input bit en, input int addr, input int dseed, input bit ovf,
                              input int col);
    vec_t v;
    v.rst = rst; v.done = done; v.rdy = rdy; v.din = din;
    v.exp_en = en; v.exp_addr = addr; v.exp_dseed = dseed; v.exp_ovf = ovf; v.exp_col = col;
    return v;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    done_accum = 1'b0;
    wr_ready   = 1'b1;
    out        = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic capture_one(input int seed);
    done_accum = 1'b1;
    out        = dat(seed);
    tick();
  endtask

  initial begin
    int bad;
    int pulses;
    bit fd_last;

    reset = 1'b0; done_accum = 1'b0; wr_ready = 1'b0; out = '0;
    #2;
    check("rst_async_wr_en", 256'(wr_en), 256'(0));
    do_reset();
    check("rst_wr_en", 256'(wr_en), 256'(0));
    check("rst_wr_addr", 256'(wr_addr), 256'(0));
    check("rst_wr_data", wr_data, '0);
    check("rst_block_row", 256'(block_row), 256'(0));
    check("rst_block_col", 256'(block_col), 256'(0));
    check("rst_frame_done", 256'(frame_done), 256'(0));
    check("rst_overflow", 256'(overflow), 256'(0));

    // Basic capture, held-high done_accum.
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 2, 1, 1, 2, 0, 2));
    vecs.push_back(mk(0, 1, 1, 3, 0, 1, 2, 0, 2));
    vecs.push_back(mk(0, 1, 1, 4, 0, 1, 2, 0, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 2, 0, 2));
    vecs.push_back(mk(0, 1, 1, 5, 1, 2, 5, 0, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 2, 5, 0, 3));
    // Stalled RAM: four held, fifth dropped, drain, next lands at 5.
    vecs.push_back(mk(1, 1, 0, 10, 1, 0, 10, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 10, 0, 1));
    vecs.push_back(mk(0, 1, 0, 11, 1, 0, 10, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 10, 0, 2));
    vecs.push_back(mk(0, 1, 0, 12, 1, 0, 10, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 10, 0, 3));
    vecs.push_back(mk(0, 1, 0, 13, 1, 0, 10, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 10, 0, 4));
    vecs.push_back(mk(0, 1, 0, 14, 1, 0, 10, 1, 5));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 11, 1, 5));
    vecs.push_back(mk(0, 0, 1, 0, 1, 2, 12, 1, 5));
    vecs.push_back(mk(0, 0, 1, 0, 1, 3, 13, 1, 5));
    vecs.push_back(mk(0, 0, 1, 0, 0, 3, 13, 1, 5));
    vecs.push_back(mk(0, 1, 1, 15, 1, 5, 15, 1, 6));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5, 15, 1, 6));
    // Full FIFO with push and pop on the same edge: nothing dropped.
    vecs.push_back(mk(1, 1, 0, 20, 1, 0, 20, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 20, 0, 1));
    vecs.push_back(mk(0, 1, 0, 21, 1, 0, 20, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 20, 0, 2));
    vecs.push_back(mk(0, 1, 0, 22, 1, 0, 20, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 20, 0, 3));
    vecs.push_back(mk(0, 1, 0, 23, 1, 0, 20, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 20, 0, 4));
    vecs.push_back(mk(0, 1, 1, 24, 1, 1, 21, 0, 5));
    vecs.push_back(mk(0, 0, 1, 0, 1, 2, 22, 0, 5));
    vecs.push_back(mk(0, 0, 1, 0, 1, 3, 23, 0, 5));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4, 24, 0, 5));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4, 24, 0, 5));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      done_accum = vecs[i].done;
      wr_ready   = vecs[i].rdy;
      out        = dat(vecs[i].din);
      tick();
      check($sformatf("v%0d_wr_en", i), 256'(wr_en), 256'(vecs[i].exp_en));
      check($sformatf("v%0d_wr_addr", i), 256'(wr_addr), 256'(vecs[i].exp_addr));
      check($sformatf("v%0d_wr_data", i), wr_data, dat(vecs[i].exp_dseed));
      check($sformatf("v%0d_overflow", i), 256'(overflow), 256'(vecs[i].exp_ovf));
      check($sformatf("v%0d_block_col", i), 256'(block_col), 256'(vecs[i].exp_col));
    end

    // Three pulses 20 cycles apart.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      capture_one(30 + i);
      check($sformatf("spaced%0d_wr_en", i), 256'(wr_en), 256'(1));
      check($sformatf("spaced%0d_wr_addr", i), 256'(wr_addr), 256'(i));
      check($sformatf("spaced%0d_wr_data", i), wr_data, dat(30 + i));
      done_accum = 1'b0;
      tick();
      check($sformatf("spaced%0d_idle", i), 256'(wr_en), 256'(0));
      for (int j = 0; j < 18; j++) tick();
    end
    check("spaced_overflow", 256'(overflow), 256'(0));

    // done_accum held for 10 cycles.
    do_reset();
    done_accum = 1'b1;
    out        = dat(40);
    for (int j = 0; j < 10; j++) tick();
    done_accum = 1'b0;
    tick();
    check("held_block_col", 256'(block_col), 256'(1));
    check("held_wr_addr", 256'(wr_addr), 256'(0));

    // 129 captures: row wrap.
    do_reset();
    bad = 0;
    for (int i = 0; i < 129; i++) begin
      capture_one(100 + i);
      if (!wr_en || wr_addr !== ADDR_W'(i)) bad++;
      done_accum = 1'b0;
      tick();
    end
    check("row_addr_seq_bad", 256'(bad), 256'(0));
    check("row_last_addr", 256'(wr_addr), 256'(128));
    check("row_last_data", wr_data, dat(228));
    check("row_block_row", 256'(block_row), 256'(1));
    check("row_block_col", 256'(block_col), 256'(1));

    // Full frame: frame_done once, addresses wrap.
    do_reset();
    bad = 0;
    pulses = 0;
    fd_last = 1'b0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      capture_one(i);
      if (!wr_en || wr_addr !== ADDR_W'(i)) bad++;
      if (frame_done) pulses++;
      done_accum = 1'b0;
      tick();
      if (frame_done) pulses++;
      if (i == ROWS * COLS - 1) fd_last = frame_done;
    end
    check("frame_addr_seq_bad", 256'(bad), 256'(0));
    check("frame_done_after_last", 256'(fd_last), 256'(1));
    check("frame_block_row_wrap", 256'(block_row), 256'(0));
    check("frame_block_col_wrap", 256'(block_col), 256'(0));
    capture_one(7);
    if (frame_done) pulses++;
    check("frame_done_pulses", 256'(pulses), 256'(1));
    check("frame_next_addr", 256'(wr_addr), 256'(0));
    check("frame_next_data", wr_data, dat(7));
    done_accum = 1'b0;
    tick();

    // Asynchronous reset with two pending entries.
    do_reset();
    wr_ready = 1'b0;
    capture_one(60);
    done_accum = 1'b0;
    tick();
    capture_one(61);
    done_accum = 1'b0;
    tick();
    check("midrst_pre_wr_en", 256'(wr_en), 256'(1));
    check("midrst_pre_col", 256'(block_col), 256'(2));
    #2;
    reset = 1'b0;
    #1;
    check("midrst_wr_en", 256'(wr_en), 256'(0));
    check("midrst_wr_addr", 256'(wr_addr), 256'(0));
    check("midrst_block_row", 256'(block_row), 256'(0));
    check("midrst_block_col", 256'(block_col), 256'(0));
    tick();
    reset    = 1'b1;
    wr_ready = 1'b1;
    capture_one(62);
    check("midrst_next_wr_en", 256'(wr_en), 256'(1));
    check("midrst_next_addr", 256'(wr_addr), 256'(0));
    check("midrst_next_data", wr_data, dat(62));
    done_accum = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
